// File: rtl/dct_blk_sched.sv
// dct_blk_sched: gathers an 8-sample frame for the shared DCT coefficient
// bank, runs the bank for a fixed enable window, captures Z0..Z7 and
// serialises them to the RLE encoder over valid/ready.
module dct_blk_sched #(
    parameter int DATA_W  = 8,
    parameter int COEF_W  = 19,
    parameter int DCT_LAT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_sample,
    input  logic                  flush,
    output logic [8*DATA_W-1:0]   dct_smp,
    output logic                  dct_en,
    output logic                  dct_cs,
    input  logic [8*COEF_W-1:0]   dct_coef,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [COEF_W-1:0]     out_coef,
    output logic [2:0]            out_idx,
    output logic                  out_last,
    output logic                  busy,
    output logic [15:0]           frame_cnt
);

    typedef enum logic [1:0] {
        ST_FILL    = 2'b00,
        ST_COMPUTE = 2'b01,
        ST_DRAIN   = 2'b10
    } state_t;

    // Window length loaded into the down-counter when COMPUTE is entered.
    localparam logic [7:0] LAT_INIT = 8'(DCT_LAT);

    state_t                   state_q, state_d;
    logic [2:0]               fill_cnt_q, fill_cnt_d;
    logic [7:0][DATA_W-1:0]   smp_q, smp_d;
    logic [7:0]               lat_cnt_q, lat_cnt_d;
    logic [7:0][COEF_W-1:0]   res_q, res_d;
    logic [2:0]               out_idx_q, out_idx_d;
    logic [15:0]              frame_cnt_q, frame_cnt_d;
    logic                     in_ready_q, in_ready_d;
    logic                     dct_en_q, dct_en_d;
    logic                     dct_cs_q, dct_cs_d;
    logic                     out_valid_q, out_valid_d;
    logic                     out_last_q, out_last_d;
    logic                     busy_q, busy_d;
    logic [COEF_W-1:0]        out_coef_q, out_coef_d;

    logic [7:0][COEF_W-1:0]   coef_in_s;
    logic                     accept_s;
    logic                     flush_go_s;
    logic [3:0]               next_slot_s;

    assign coef_in_s = dct_coef;

    // Next-state, datapath and registered-output computation for all flops.
    always_comb begin
        state_d     = state_q;
        fill_cnt_d  = fill_cnt_q;
        smp_d       = smp_q;
        lat_cnt_d   = lat_cnt_q;
        res_d       = res_q;
        out_idx_d   = out_idx_q;
        frame_cnt_d = frame_cnt_q;
        out_coef_d  = out_coef_q;
        out_last_d  = out_last_q;

        accept_s    = (state_q == ST_FILL) && in_valid && in_ready_q;
        // First slot not holding a real sample once this cycle's sample lands.
        next_slot_s = {1'b0, fill_cnt_q} + {3'b000, accept_s};
        // A flush with nothing gathered (and nothing arriving) is ignored.
        flush_go_s  = (state_q == ST_FILL) && flush && (next_slot_s != 4'd0);

        case (state_q)
            ST_FILL: begin
                for (int k = 0; k < 8; k++) begin
                    if (accept_s && (fill_cnt_q == 3'(k))) begin
                        smp_d[k] = in_sample;
                    end else if (flush_go_s && (4'(k) >= next_slot_s)) begin
                        smp_d[k] = '0;
                    end else begin
                        smp_d[k] = smp_q[k];
                    end
                end
                if ((accept_s && (fill_cnt_q == 3'd7)) || flush_go_s) begin
                    state_d    = ST_COMPUTE;
                    fill_cnt_d = 3'd0;
                    lat_cnt_d  = LAT_INIT;
                end else if (accept_s) begin
                    fill_cnt_d = fill_cnt_q + 3'd1;
                end else begin
                    fill_cnt_d = fill_cnt_q;
                end
            end
            ST_COMPUTE: begin
                if (lat_cnt_q <= 8'd1) begin
                    // Bank output is valid at the end of the last window cycle.
                    res_d      = coef_in_s;
                    state_d    = ST_DRAIN;
                    out_idx_d  = 3'd0;
                    out_coef_d = coef_in_s[0];
                    out_last_d = 1'b0;
                end else begin
                    lat_cnt_d  = lat_cnt_q - 8'd1;
                end
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    if (out_idx_q == 3'd7) begin
                        state_d     = ST_FILL;
                        out_idx_d   = 3'd0;
                        out_coef_d  = '0;
                        out_last_d  = 1'b0;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end else begin
                        out_idx_d  = out_idx_q + 3'd1;
                        out_coef_d = res_q[out_idx_q + 3'd1];
                        out_last_d = (out_idx_q == 3'd6);
                    end
                end else begin
                    out_idx_d = out_idx_q;
                end
            end
            default: begin
                state_d    = ST_FILL;
                fill_cnt_d = 3'd0;
            end
        endcase

        in_ready_d  = (state_d == ST_FILL);
        dct_en_d    = (state_d == ST_COMPUTE);
        dct_cs_d    = (state_d == ST_COMPUTE);
        out_valid_d = (state_d == ST_DRAIN);
        busy_d      = (state_d == ST_COMPUTE) || (state_d == ST_DRAIN);
    end

    // State register and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_FILL;
            fill_cnt_q  <= 3'd0;
            smp_q       <= '0;
            lat_cnt_q   <= 8'd0;
            res_q       <= '0;
            out_idx_q   <= 3'd0;
            frame_cnt_q <= 16'd0;
            in_ready_q  <= 1'b1;
            dct_en_q    <= 1'b0;
            dct_cs_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            out_coef_q  <= '0;
        end else begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            smp_q       <= smp_d;
            lat_cnt_q   <= lat_cnt_d;
            res_q       <= res_d;
            out_idx_q   <= out_idx_d;
            frame_cnt_q <= frame_cnt_d;
            in_ready_q  <= in_ready_d;
            dct_en_q    <= dct_en_d;
            dct_cs_q    <= dct_cs_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            out_coef_q  <= out_coef_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign dct_smp   = smp_q;
    assign dct_en    = dct_en_q;
    assign dct_cs    = dct_cs_q;
    assign out_valid = out_valid_q;
    assign out_coef  = out_coef_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_dct_blk_sched.sv
// Testbench for dct_blk_sched: drives frames, models the DCT bank (coefficients
// valid only in the last enable cycle) and checks against a frame-level model.
module tb_dct_blk_sched;

    localparam int DW  = 8;
    localparam int CW  = 19;
    localparam int LAT = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     in_sample;
    logic              flush;
    logic [8*DW-1:0]   dct_smp;
    logic              dct_en;
    logic              dct_cs;
    logic [8*CW-1:0]   dct_coef;
    logic              out_valid;
    logic              out_ready;
    logic [CW-1:0]     out_coef;
    logic [2:0]        out_idx;
    logic              out_last;
    logic              busy;
    logic [15:0]       frame_cnt;

    dct_blk_sched #(.DATA_W(DW), .COEF_W(CW), .DCT_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_sample(in_sample), .flush(flush), .dct_smp(dct_smp),
        .dct_en(dct_en), .dct_cs(dct_cs), .dct_coef(dct_coef),
        .out_valid(out_valid), .out_ready(out_ready), .out_coef(out_coef),
        .out_idx(out_idx), .out_last(out_last), .busy(busy),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int exp_frames  = 0;
    int t_first     = 0;
    int en_run      = 0;

    // frame description used by do_frame
    logic signed [DW-1:0] f_smp[8];
    logic [CW-1:0]        f_coef[8];
    int f_n, f_stall_idx, f_stall_len;
    bit f_flush_same, f_bubbles, f_hold, f_junk, f_rand_ready;

    always @(posedge clk) cyc <= cyc + 1;

    // DCT bank model: correct results only during the last cycle of the window.
    always @(negedge clk) begin
        if (dct_en) en_run = en_run + 1;
        else        en_run = 0;
        for (int k = 0; k < 8; k++)
            dct_coef[k*CW +: CW] = (dct_en && en_run == LAT) ? f_coef[k] : CW'($urandom);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cfg_default();
        f_n = 8; f_flush_same = 0; f_bubbles = 0; f_hold = 0; f_junk = 0;
        f_rand_ready = 0; f_stall_idx = -1; f_stall_len = 0;
    endtask

    task automatic apply_reset(input int cycles);
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_sample = '0;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
        exp_frames = 0;
    endtask

    // Drive one complete frame and check fill, compute window and drain.
    task automatic do_frame();
        int idx, guard, stall_rem;
        logic [8*DW-1:0] exp_smp;
        logic [2:0] idx3;
        for (int k = 0; k < 8; k++) exp_smp[k*DW +: DW] = (k < f_n) ? f_smp[k] : '0;
        for (int i = 0; i < f_n; i++) begin
            if (f_bubbles) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0; flush = 1'b0; in_sample = DW'($urandom);
                    @(negedge clk);
                end
            end
            vectors++;
            if (in_ready !== 1'b1 || dct_en !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL fill slot %0d: in_ready=%b dct_en=%b busy=%b, required 1 0 0",
                         i, in_ready, dct_en, busy);
            end
            in_valid = 1'b1; in_sample = f_smp[i];
            flush = (i == f_n - 1) && (f_n < 8) && f_flush_same;
            if (i == 0) t_first = cyc;
            @(negedge clk);
        end
        if (f_n < 8 && !f_flush_same) begin
            in_valid = 1'b0; flush = 1'b1;
            @(negedge clk);
        end
        in_valid = f_hold; in_sample = DW'($urandom); flush = 1'b0;
        for (int j = 1; j <= LAT; j++) begin
            vectors++;
            if (dct_en !== 1'b1 || dct_cs !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 ||
                out_valid !== 1'b0 || dct_smp !== exp_smp) begin
                miscompares++;
                $display("FAIL compute cycle %0d: en=%b cs=%b in_ready=%b busy=%b out_valid=%b smp=%h, required 1 1 0 1 0 smp=%h",
                         j, dct_en, dct_cs, in_ready, busy, out_valid, dct_smp, exp_smp);
            end
            if (f_junk) flush = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        idx = 0; guard = 0; stall_rem = f_stall_len;
        while (idx < 8 && guard < 200) begin
            idx3 = 3'(idx);
            vectors++;
            if (out_valid !== 1'b1 || out_idx !== idx3 || out_coef !== f_coef[idx] ||
                out_last !== (idx == 7) || in_ready !== 1'b0 || dct_en !== 1'b0 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL drain idx %0d: valid=%b idx=%0d coef=%h last=%b in_ready=%b en=%b busy=%b, required 1 %0d %h %b 0 0 1",
                         idx, out_valid, out_idx, out_coef, out_last, in_ready, dct_en, busy,
                         idx, f_coef[idx], (idx == 7));
            end
            if (idx == f_stall_idx && stall_rem > 0) begin
                out_ready = 1'b0; stall_rem--;
            end else if (f_rand_ready) begin
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                out_ready = 1'b1;
            end
            if (f_junk) flush = 1'($urandom_range(0, 1));
            if (out_ready) idx++;
            guard++;
            @(negedge clk);
        end
        if (guard >= 200) begin
            miscompares++;
            $display("FAIL drain timeout: got %0d of 8 coefficients", idx);
        end
        flush = 1'b0;
        exp_frames++;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || dct_en !== 1'b0 ||
            frame_cnt !== 16'(exp_frames)) begin
            miscompares++;
            $display("FAIL end of frame: valid=%b in_ready=%b busy=%b en=%b frame_cnt=%0d, required 0 1 0 0 %0d",
                     out_valid, in_ready, busy, dct_en, frame_cnt, 16'(exp_frames));
        end
    endtask

    task automatic test_reset();
        apply_reset(2);
        vectors++;
        if (in_ready !== 1'b1 || dct_en !== 1'b0 || dct_cs !== 1'b0 || out_valid !== 1'b0 ||
            out_coef !== '0 || out_idx !== 3'd0 || out_last !== 1'b0 || busy !== 1'b0 ||
            frame_cnt !== 16'd0 || dct_smp !== '0) begin
            miscompares++;
            $display("FAIL reset: in_ready=%b en=%b cs=%b valid=%b coef=%h idx=%0d last=%b busy=%b fcnt=%0d smp=%h, required 1 0 0 0 0 0 0 0 0 0",
                     in_ready, dct_en, dct_cs, out_valid, out_coef, out_idx, out_last, busy, frame_cnt, dct_smp);
        end
    endtask

    task automatic test_basic();
        cfg_default();
        for (int k = 0; k < 8; k++) begin
            f_smp[k]  = DW'(k + 1);
            f_coef[k] = CW'(1000 * (k + 1));
        end
        do_frame();
    endtask

    task automatic test_flush();
        cfg_default();
        in_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || dct_en !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL empty flush: in_ready=%b en=%b busy=%b, required 1 0 0", in_ready, dct_en, busy);
        end
        f_n = 4; f_flush_same = 1;
        f_smp[0] = 8'sd10; f_smp[1] = -8'sd20; f_smp[2] = 8'sd30; f_smp[3] = -8'sd5;
        for (int k = 0; k < 8; k++) f_coef[k] = CW'($urandom);
        do_frame();
    endtask

    task automatic test_stall();
        cfg_default();
        for (int k = 0; k < 8; k++) begin
            f_smp[k]  = DW'($urandom);
            f_coef[k] = CW'(1000 * (k + 1));
        end
        f_stall_idx = 3; f_stall_len = 5;
        do_frame();
    endtask

    task automatic test_rst_mid_compute();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_sample = DW'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (dct_en !== 1'b1) begin
            miscompares++;
            $display("FAIL pre-reset compute: dct_en=%b, required 1", dct_en);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_frames = 0;
        vectors++;
        if (dct_en !== 1'b0 || in_ready !== 1'b1 || frame_cnt !== 16'd0 || busy !== 1'b0 ||
            out_valid !== 1'b0 || dct_smp !== '0) begin
            miscompares++;
            $display("FAIL reset mid compute: en=%b in_ready=%b fcnt=%0d busy=%b valid=%b smp=%h, required 0 1 0 0 0 0",
                     dct_en, in_ready, frame_cnt, busy, out_valid, dct_smp);
        end
        cfg_default();
        for (int k = 0; k < 8; k++) begin
            f_smp[k] = DW'($urandom); f_coef[k] = CW'($urandom);
        end
        do_frame();
    endtask

    task automatic test_back_to_back();
        int t1;
        apply_reset(1);
        cfg_default();
        f_hold = 1;
        for (int k = 0; k < 8; k++) begin
            f_smp[k] = DW'($urandom); f_coef[k] = CW'($urandom);
        end
        do_frame();
        t1 = t_first;
        for (int k = 0; k < 8; k++) begin
            f_smp[k] = DW'($urandom); f_coef[k] = CW'($urandom);
        end
        do_frame();
        in_valid = 1'b0;
        vectors++;
        if (t_first - t1 != 24 || frame_cnt !== 16'd2) begin
            miscompares++;
            $display("FAIL back to back: period=%0d frame_cnt=%0d, required 24 2", t_first - t1, frame_cnt);
        end
    endtask

    task automatic test_wrap();
        force dut.frame_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.frame_cnt_q;
        @(negedge clk);
        exp_frames = 65535;
        vectors++;
        if (frame_cnt !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL preload frame_cnt: got %h, required ffff", frame_cnt);
        end
        cfg_default();
        for (int k = 0; k < 8; k++) begin
            f_smp[k] = DW'($urandom); f_coef[k] = CW'($urandom);
        end
        f_coef[0] = 19'h40000;
        do_frame();
    endtask

    task automatic test_random();
        repeat (6) begin
            cfg_default();
            f_n = $urandom_range(1, 8);
            f_flush_same = 1'($urandom_range(0, 1));
            f_bubbles = 1; f_junk = 1; f_rand_ready = 1;
            f_hold = 1'($urandom_range(0, 1));
            f_stall_idx = $urandom_range(0, 7);
            f_stall_len = $urandom_range(0, 3);
            for (int k = 0; k < 8; k++) begin
                f_smp[k] = DW'($urandom); f_coef[k] = CW'($urandom);
            end
            do_frame();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_sample = '0;
        cfg_default();
        for (int k = 0; k < 8; k++) begin
            f_smp[k] = '0; f_coef[k] = '0;
        end
        @(negedge clk);
        test_reset();
        test_basic();
        test_flush();
        test_stall();
        test_rst_mid_compute();
        test_back_to_back();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
